// File: rtl/pwm_pkg.sv
// Shared default constants for the multi-channel PWM generator.
// Firmware pwm.h carries the same values; keep the two in step.
package pwm_pkg;

  localparam int PWM_NUM_CH    = 2;
  localparam int PWM_DUTY_W    = 8;
  localparam int PWM_PERIOD    = 400000;  // clock cycles per PWM period
  localparam int PWM_MIN_WIDTH = 200000;  // 50 % floor on high time
  localparam int PWM_MAX_WIDTH = 360000;  // 90 % ceiling on high time
  localparam int PWM_RAMP_STEP = 4000;    // max high-time change per period

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: duty-to-width conversion, clamp, optional slew limit,
// period-boundary latching of the applied width and enable, and the
// registered output compare.
// Optional feature macro: PWM_RAMP_EN (slew-limit applied width changes).
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int DUTY_W    = PWM_DUTY_W,
  parameter int PERIOD    = PWM_PERIOD,
  parameter int MIN_WIDTH = PWM_MIN_WIDTH,
  parameter int MAX_WIDTH = PWM_MAX_WIDTH,
  parameter int RAMP_STEP = PWM_RAMP_STEP,
  parameter int CW        = $clog2(PWM_PERIOD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty,
  input  logic              enable,
  input  logic [CW-1:0]     count,
  input  logic              boundary,
  output logic              pwm
);

  // Widths are one bit wider than the counter so a width equal to PERIOD
  // still fits when PERIOD is a power of two.
  localparam int AW = CW + 1;
  localparam int PW = DUTY_W + CW + 1;
  localparam logic [AW-1:0] MIN_C = AW'(MIN_WIDTH);
  localparam logic [AW-1:0] MAX_C = AW'(MAX_WIDTH);

  if (RAMP_STEP < 1) begin : g_bad_step
    $error("pwm_chan: RAMP_STEP must be at least 1");
  end

  logic [PW-1:0] product;
  logic [AW-1:0] raw;
  logic [AW-1:0] target;
  logic [AW-1:0] applied;
  logic [AW-1:0] applied_next;
  logic          en_q;

  // Scale the duty code to a high time in cycles and clamp it.
  always_comb begin
    product = PW'(duty) * PW'(PERIOD);
    raw     = AW'(product >> DUTY_W);
    if (raw < MIN_C)
      target = MIN_C;
    else if (raw > MAX_C)
      target = MAX_C;
    else
      target = raw;
  end

`ifdef PWM_RAMP_EN
  localparam int            STEP_I = (RAMP_STEP > PERIOD) ? PERIOD : RAMP_STEP;
  localparam logic [AW-1:0] STEP_C = AW'(STEP_I);

  // Move toward the target by at most one step; differences are taken
  // larger-minus-smaller so nothing wraps.
  always_comb begin
    applied_next = target;
    if (target > applied) begin
      if ((target - applied) > STEP_C)
        applied_next = applied + STEP_C;
    end else if ((applied - target) > STEP_C) begin
      applied_next = applied - STEP_C;
    end
  end
`else
  assign applied_next = target;
`endif

  // Latch enable and width only at the period boundary; a disabled channel
  // parks at MIN_WIDTH so re-enabling ramps up from the floor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      applied <= MIN_C;
      en_q    <= 1'b0;
    end else if (boundary) begin
      en_q    <= enable;
      applied <= enable ? applied_next : MIN_C;
    end
  end

  // Registered compare against the shared counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pwm <= 1'b0;
    else
      pwm <= en_q & ({1'b0, count} < applied);
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator top: shared period counter, period_start
// strobe and one pwm_chan per channel.
// Optional feature macro: PWM_RAMP_EN (passed through to pwm_chan).
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NUM_CH    = PWM_NUM_CH,
  parameter int DUTY_W    = PWM_DUTY_W,
  parameter int PERIOD    = PWM_PERIOD,
  parameter int MIN_WIDTH = PWM_MIN_WIDTH,
  parameter int MAX_WIDTH = PWM_MAX_WIDTH,
  parameter int RAMP_STEP = PWM_RAMP_STEP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DUTY_W-1:0] duty,
  input  logic [NUM_CH-1:0]        enable,
  output logic [NUM_CH-1:0]        pwm,
  output logic                     period_start
);

  localparam int            CW   = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  if (PERIOD < 2 || MIN_WIDTH > MAX_WIDTH || MAX_WIDTH > PERIOD) begin : g_bad_params
    $error("pwm_multi: illegal PERIOD/MIN_WIDTH/MAX_WIDTH combination");
  end

  logic [CW-1:0] count;
  logic          boundary;

  assign boundary = (count == LAST);

  // Free-running period counter, 0..PERIOD-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (boundary)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  // One-cycle strobe aligned with count == 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      period_start <= 1'b0;
    else
      period_start <= boundary;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    pwm_chan #(
      .DUTY_W   (DUTY_W),
      .PERIOD   (PERIOD),
      .MIN_WIDTH(MIN_WIDTH),
      .MAX_WIDTH(MAX_WIDTH),
      .RAMP_STEP(RAMP_STEP),
      .CW       (CW)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .duty    (duty[i*DUTY_W +: DUTY_W]),
      .enable  (enable[i]),
      .count   (count),
      .boundary(boundary),
      .pwm     (pwm[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi with a small-period configuration.
// Reference model works per period: each channel has an applied high time
// and an enable, both re-evaluated from the inputs at every period end.
// pwm lags the counter by one cycle, so inside a period (sample 0 = the
// period_start cycle) the channel is high on samples 1..applied.
module tb_pwm_multi;

  localparam int NUM_CH    = 2;
  localparam int DUTY_W    = 8;
  localparam int PERIOD    = 16;
  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 14;
  localparam int RAMP_STEP = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH*DUTY_W-1:0] duty = '0;
  logic [NUM_CH-1:0]        enable = '0;
  logic [NUM_CH-1:0]        pwm;
  logic                     period_start;

  int vectors = 0;
  int errors  = 0;

  int app_m[NUM_CH];
  bit en_m[NUM_CH];

  pwm_multi #(
    .NUM_CH   (NUM_CH),
    .DUTY_W   (DUTY_W),
    .PERIOD   (PERIOD),
    .MIN_WIDTH(MIN_WIDTH),
    .MAX_WIDTH(MAX_WIDTH),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .duty        (duty),
    .enable      (enable),
    .pwm         (pwm),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  // High time the channel should use next period, from the rules in words.
  function automatic int next_app(int cur, int d, bit en);
    int raw, t, step;
    if (!en) return MIN_WIDTH;
    raw = (d * PERIOD) / (1 << DUTY_W);
    t = (raw < MIN_WIDTH) ? MIN_WIDTH : (raw > MAX_WIDTH) ? MAX_WIDTH : raw;
`ifdef PWM_RAMP_EN
    step = RAMP_STEP;
`else
    step = PERIOD;
`endif
    if (t > cur + step) return cur + step;
    if (t + step < cur) return cur - step;
    return t;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      app_m[c] = MIN_WIDTH;
      en_m[c]  = 1'b0;
    end
  endfunction

  // Release reset on a falling edge and expect the first period_start
  // exactly PERIOD edges later with all outputs low until then.
  task automatic release_and_sync(input string tag);
    int found;
    bit pwm_bad;
    found   = 0;
    pwm_bad = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 3 * PERIOD; k++) begin
      @(negedge clk);
      if (pwm !== '0) pwm_bad = 1'b1;
      if (period_start === 1'b1) begin
        found = k;
        break;
      end
    end
    vectors++;
    if (found != PERIOD) begin
      errors++;
      $display("FAIL %s_first_ps: period_start after %0d edges, expected %0d", tag, found, PERIOD);
    end
    vectors++;
    if (pwm_bad) begin
      errors++;
      $display("FAIL %s_first_period_pwm: pwm went high, expected 0 before first boundary", tag);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      app_m[c] = next_app(app_m[c], duty[c*DUTY_W +: DUTY_W], enable[c]);
      en_m[c]  = enable[c];
    end
  endtask

  // Observe one full period starting at a period_start sample, optionally
  // changing inputs at sample change_at, then advance to the next start.
  task automatic run_period(input string tag, input int change_at,
                            input logic [NUM_CH*DUTY_W-1:0] new_duty,
                            input logic [NUM_CH-1:0] new_en);
    int hi[NUM_CH];
    logic [PERIOD-1:0] wave[NUM_CH];
    bit bad[NUM_CH];
    int ps_extra;
    bit exp_bit;
    ps_extra = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      hi[c] = 0; bad[c] = 1'b0; wave[c] = '0;
    end
    for (int j = 0; j < PERIOD; j++) begin
      if (j > 0) @(negedge clk);
      if (j > 0 && period_start !== 1'b0) ps_extra++;
      for (int c = 0; c < NUM_CH; c++) begin
        exp_bit = en_m[c] && (j >= 1) && ((j - 1) < app_m[c]);
        wave[c][j] = pwm[c];
        if (pwm[c] === 1'b1) hi[c]++;
        if (pwm[c] !== exp_bit) bad[c] = 1'b1;
      end
      if (j == change_at) begin
        duty   = new_duty;
        enable = new_en;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      vectors++;
      if (bad[c]) begin
        errors++;
        $display("FAIL %s_wave_ch%0d: got %0d high cycles (samples %b), expected %0d from sample 1",
                 tag, c, hi[c], wave[c], en_m[c] ? app_m[c] : 0);
      end
    end
    vectors++;
    if (ps_extra != 0) begin
      errors++;
      $display("FAIL %s_ps_inside: %0d extra period_start cycles, expected 0", tag, ps_extra);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      app_m[c] = next_app(app_m[c], duty[c*DUTY_W +: DUTY_W], enable[c]);
      en_m[c]  = enable[c];
    end
    @(negedge clk);
    vectors++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_ps_spacing: period_start=%b at period end, expected 1", tag, period_start);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    duty   = '0;
    enable = '0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (pwm !== '0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: pwm=%b period_start=%b, expected 00/0", pwm, period_start);
    end
    release_and_sync("reset");
    run_period("reset_idle", -1, duty, enable);
  endtask

  task automatic test_nominal();
    duty   = {8'd77, 8'd128};
    enable = 2'b01;
    for (int p = 0; p < 4; p++) run_period("nominal", -1, duty, enable);
  endtask

  task automatic test_clamps();
    duty   = {8'd255, 8'd255};
    enable = 2'b11;
    for (int p = 0; p < 5; p++) run_period("clamp_hi", -1, duty, enable);
    duty = {8'd0, 8'd0};
    for (int p = 0; p < 5; p++) run_period("clamp_lo", -1, duty, enable);
  endtask

  task automatic test_ramp();
    duty   = {8'd0, 8'd0};
    enable = 2'b01;
    for (int p = 0; p < 3; p++) run_period("ramp_settle", -1, duty, enable);
    duty = {8'd0, 8'd255};
    for (int p = 0; p < 5; p++) run_period("ramp_up", -1, duty, enable);
    duty = {8'd0, 8'd128};
    for (int p = 0; p < 5; p++) run_period("ramp_down", -1, duty, enable);
  endtask

  task automatic test_mid_period();
    duty   = {8'd0, 8'd128};
    enable = 2'b01;
    for (int p = 0; p < 4; p++) run_period("mid_settle", -1, duty, enable);
    run_period("mid_duty", 3, {8'd0, 8'd224}, 2'b01);
    for (int p = 0; p < 3; p++) run_period("mid_after", -1, duty, enable);
    run_period("mid_disable", 5, duty, 2'b00);
    run_period("mid_off", -1, duty, enable);
    run_period("mid_reenable", 0, duty, 2'b01);
    for (int p = 0; p < 4; p++) run_period("mid_reenabled", -1, duty, enable);
  endtask

  task automatic test_random();
    for (int p = 0; p < 30; p++) begin
      if (p % 3 == 0) begin
        duty   = NUM_CH*DUTY_W'($urandom);
        enable = NUM_CH'($urandom_range(0, 3));
      end
      run_period("random", int'($urandom_range(0, PERIOD + 4)),
                 NUM_CH*DUTY_W'($urandom), NUM_CH'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_async_reset();
    bit exp_bit;
    duty   = {8'd0, 8'd255};
    enable = 2'b01;
    for (int p = 0; p < 5; p++) run_period("areset_settle", -1, duty, enable);
    repeat (9) @(posedge clk);
    #2;
    exp_bit = en_m[0] && (8 < app_m[0]);
    vectors++;
    if (pwm[0] !== exp_bit) begin
      errors++;
      $display("FAIL areset_pre: pwm[0]=%b at count 9, expected %b", pwm[0], exp_bit);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pwm !== '0 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: pwm=%b period_start=%b between edges, expected 00/0",
               pwm, period_start);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    release_and_sync("areset");
    for (int p = 0; p < 3; p++) run_period("areset_after", -1, duty, enable);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_clamps();
    test_ramp();
    test_mid_period();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
